// File: rtl/vlog_tap_parser.sv
`default_nettype none
// ============================================================================
//  Module      : vlog_tap_parser
//  Description : TAP text stream reader. It parses the plan line and the
//                ok / not ok result lines, emits one event per result and
//                keeps pass/fail counters plus a sticky first-error code.
//  Revision    : 1.0 - initial release
// ============================================================================
module vlog_tap_parser #(
    parameter int CNT_W      = 16,
    parameter int MAX_DIGITS = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       byte_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic             ev_valid_o,
    input  logic             ev_ready_i,
    output logic             ev_ok_o,
    output logic [CNT_W-1:0] ev_num_o,
    output logic             plan_valid_o,
    output logic [CNT_W-1:0] plan_o,
    output logic [CNT_W-1:0] pass_cnt_o,
    output logic [CNT_W-1:0] fail_cnt_o,
    output logic             err_o,
    output logic [2:0]       err_code_o,
    output logic             done_o,
    output logic             all_pass_o
);

    localparam int DIG_W = $clog2(MAX_DIGITS + 1);

    localparam logic [3:0] S_LINE_START = 4'd0;
    localparam logic [3:0] S_PLAN_DOT1  = 4'd1;
    localparam logic [3:0] S_PLAN_DOT2  = 4'd2;
    localparam logic [3:0] S_PLAN_NUM   = 4'd3;
    localparam logic [3:0] S_NOT_O      = 4'd4;
    localparam logic [3:0] S_NOT_T      = 4'd5;
    localparam logic [3:0] S_NOT_SP     = 4'd6;
    localparam logic [3:0] S_OK_O       = 4'd7;
    localparam logic [3:0] S_OK_K       = 4'd8;
    localparam logic [3:0] S_OK_SP      = 4'd9;
    localparam logic [3:0] S_NUM        = 4'd10;
    localparam logic [3:0] S_SKIP_DESC  = 4'd11;
    localparam logic [3:0] S_SKIP       = 4'd12;

    localparam logic [2:0] c_err_syntax = 3'd1;
    localparam logic [2:0] c_err_noplan = 3'd2;
    localparam logic [2:0] c_err_dup    = 3'd3;
    localparam logic [2:0] c_err_seq    = 3'd4;
    localparam logic [2:0] c_err_ovf    = 3'd5;
    localparam logic [2:0] c_err_beyond = 3'd6;

    logic [3:0]       r_state;
    logic [CNT_W-1:0] r_acc;
    logic [DIG_W-1:0] r_ndig;
    logic             r_is_ok;
    logic             r_ev_valid;
    logic             r_ev_ok;
    logic [CNT_W-1:0] r_ev_num;
    logic             r_plan_valid;
    logic [CNT_W-1:0] r_plan;
    logic [CNT_W-1:0] r_pass;
    logic [CNT_W-1:0] r_fail;
    logic             r_err;
    logic [2:0]       r_err_code;

    logic             w_accept;
    logic             w_is_nl;
    logic             w_is_digit;
    logic [CNT_W+3:0] w_acc_ext;
    logic             w_num_ovf;
    logic [CNT_W:0]   w_expect;
    logic [3:0]       w_state_nxt;
    logic [CNT_W-1:0] w_acc_nxt;
    logic [DIG_W-1:0] w_ndig_nxt;
    logic             w_is_ok_nxt;
    logic             w_err_set;
    logic [2:0]       w_err_code;
    logic             w_plan_load;
    logic             w_ev_fire;

    assign w_accept   = valid_i && !r_ev_valid;
    assign w_is_nl    = (byte_i == 8'h0A);
    assign w_is_digit = (byte_i >= 8'h30) && (byte_i <= 8'h39);
    assign w_acc_ext  = ({4'b0, r_acc} * (CNT_W+4)'(10)) + {{CNT_W{1'b0}}, byte_i[3:0]};
    assign w_num_ovf  = (r_ndig >= DIG_W'(MAX_DIGITS)) || (|w_acc_ext[CNT_W+3:CNT_W]);
    assign w_expect   = {1'b0, r_pass} + {1'b0, r_fail} + {{CNT_W{1'b0}}, 1'b1};

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_ndig_nxt  = r_ndig;
        w_is_ok_nxt = r_is_ok;
        w_err_set   = 1'b0;
        w_err_code  = 3'd0;
        w_plan_load = 1'b0;
        w_ev_fire   = 1'b0;

        if (w_accept && (byte_i != 8'h0D)) begin
            case (r_state)
                S_LINE_START: begin
                    w_acc_nxt  = '0;
                    w_ndig_nxt = '0;
                    if (byte_i == "1")       w_state_nxt = S_PLAN_DOT1;
                    else if (byte_i == "n") begin
                        w_state_nxt = S_NOT_O;
                        w_is_ok_nxt = 1'b0;
                    end else if (byte_i == "o") begin
                        w_state_nxt = S_OK_K;
                        w_is_ok_nxt = 1'b1;
                    end else if (byte_i == "#") w_state_nxt = S_SKIP;
                    else if (!w_is_nl) begin
                        w_err_set   = 1'b1;
                        w_err_code  = c_err_syntax;
                        w_state_nxt = S_SKIP;
                    end
                end
                S_PLAN_DOT1, S_PLAN_DOT2, S_NOT_O, S_NOT_T, S_NOT_SP,
                S_OK_O, S_OK_K, S_OK_SP: begin
                    if ((r_state == S_PLAN_DOT1) && (byte_i == "."))      w_state_nxt = S_PLAN_DOT2;
                    else if ((r_state == S_PLAN_DOT2) && (byte_i == ".")) w_state_nxt = S_PLAN_NUM;
                    else if ((r_state == S_NOT_O) && (byte_i == "o"))     w_state_nxt = S_NOT_T;
                    else if ((r_state == S_NOT_T) && (byte_i == "t"))     w_state_nxt = S_NOT_SP;
                    else if ((r_state == S_NOT_SP) && (byte_i == " "))    w_state_nxt = S_OK_O;
                    else if ((r_state == S_OK_O) && (byte_i == "o"))      w_state_nxt = S_OK_K;
                    else if ((r_state == S_OK_K) && (byte_i == "k"))      w_state_nxt = S_OK_SP;
                    else if ((r_state == S_OK_SP) && (byte_i == " "))     w_state_nxt = S_NUM;
                    else begin
                        w_err_set   = 1'b1;
                        w_err_code  = c_err_syntax;
                        w_state_nxt = w_is_nl ? S_LINE_START : S_SKIP;
                    end
                end
                S_PLAN_NUM, S_NUM: begin
                    if (w_is_digit) begin
                        if (w_num_ovf) begin
                            w_err_set   = 1'b1;
                            w_err_code  = c_err_ovf;
                            w_state_nxt = S_SKIP;
                        end else begin
                            w_acc_nxt  = w_acc_ext[CNT_W-1:0];
                            w_ndig_nxt = r_ndig + 1'b1;
                        end
                    end else if ((r_state == S_NUM) && (byte_i == " ") && (r_ndig != '0)) begin
                        w_state_nxt = S_SKIP_DESC;
                    end else if (w_is_nl && (r_ndig != '0)) begin
                        w_state_nxt = S_LINE_START;
                        if (r_state == S_PLAN_NUM) begin
                            if (r_plan_valid) begin
                                w_err_set  = 1'b1;
                                w_err_code = c_err_dup;
                            end else if (r_acc == '0) begin
                                w_err_set  = 1'b1;
                                w_err_code = c_err_syntax;
                            end else begin
                                w_plan_load = 1'b1;
                            end
                        end else begin
                            w_ev_fire = 1'b1;
                        end
                    end else begin
                        w_err_set   = 1'b1;
                        w_err_code  = c_err_syntax;
                        w_state_nxt = w_is_nl ? S_LINE_START : S_SKIP;
                    end
                end
                S_SKIP_DESC: begin
                    if (w_is_nl) begin
                        w_state_nxt = S_LINE_START;
                        w_ev_fire   = 1'b1;
                    end
                end
                S_SKIP: begin
                    if (w_is_nl) w_state_nxt = S_LINE_START;
                end
                default: w_state_nxt = S_LINE_START;
            endcase

            // A completed result line without a plan is dropped; otherwise the
            // event goes out even when it is out of sequence or beyond the plan.
            if (w_ev_fire) begin
                if (!r_plan_valid) begin
                    w_ev_fire  = 1'b0;
                    w_err_set  = 1'b1;
                    w_err_code = c_err_noplan;
                end else if ({1'b0, r_acc} != w_expect) begin
                    w_err_set  = 1'b1;
                    w_err_code = c_err_seq;
                end else if (r_acc > r_plan) begin
                    w_err_set  = 1'b1;
                    w_err_code = c_err_beyond;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_LINE_START;
            r_acc        <= '0;
            r_ndig       <= '0;
            r_is_ok      <= 1'b0;
            r_ev_valid   <= 1'b0;
            r_ev_ok      <= 1'b0;
            r_ev_num     <= '0;
            r_plan_valid <= 1'b0;
            r_plan       <= '0;
            r_pass       <= '0;
            r_fail       <= '0;
            r_err        <= 1'b0;
            r_err_code   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_ndig  <= w_ndig_nxt;
            r_is_ok <= w_is_ok_nxt;
            if (r_ev_valid && ev_ready_i) r_ev_valid <= 1'b0;
            if (w_ev_fire) begin
                r_ev_valid <= 1'b1;
                r_ev_ok    <= r_is_ok;
                r_ev_num   <= r_acc;
                if (r_is_ok) begin
                    if (r_pass != {CNT_W{1'b1}}) r_pass <= r_pass + 1'b1;
                end else begin
                    if (r_fail != {CNT_W{1'b1}}) r_fail <= r_fail + 1'b1;
                end
            end
            if (w_plan_load) begin
                r_plan_valid <= 1'b1;
                r_plan       <= r_acc;
            end
            if (w_err_set && !r_err) begin
                r_err      <= 1'b1;
                r_err_code <= w_err_code;
            end
        end
    end

    assign ready_o      = !r_ev_valid;
    assign ev_valid_o   = r_ev_valid;
    assign ev_ok_o      = r_ev_ok;
    assign ev_num_o     = r_ev_num;
    assign plan_valid_o = r_plan_valid;
    assign plan_o       = r_plan;
    assign pass_cnt_o   = r_pass;
    assign fail_cnt_o   = r_fail;
    assign err_o        = r_err;
    assign err_code_o   = r_err_code;
    assign done_o       = r_plan_valid && (({1'b0, r_pass} + {1'b0, r_fail}) == {1'b0, r_plan});
    assign all_pass_o   = done_o && (r_fail == '0) && !r_err;

endmodule
`default_nettype wire

// File: doc/vlog_tap_parser.md
Name: vlog_tap_parser

Overview:
- Byte-stream parser for TAP (Test Anything Protocol) text, the reader counterpart of the testbench TAP writer.
- Consumes ASCII bytes over a valid/ready stream and extracts the plan line "1..N".
- Emits one result event per "ok K ..." / "not ok K ..." line, keeps pass/fail counters and flags protocol errors.
- Used in self-checking benches and log-replay harnesses to judge a TAP stream in simulation or on hardware.

Parameters:
CNT_W, 16, width of plan value, test numbers and counters
MAX_DIGITS, 5, maximum decimal digits accepted in any number field

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
byte_i  in  8  ASCII input byte
valid_i  in  1  byte_i valid
ready_o  out  1  parser accepts byte this cycle
ev_valid_o  out  1  result event valid
ev_ready_i  in  1  result event consumed
ev_ok_o  out  1  1 = "ok", 0 = "not ok"
ev_num_o  out  CNT_W  test number of event
plan_valid_o  out  1  plan line parsed
plan_o  out  CNT_W  planned test count
pass_cnt_o  out  CNT_W  "ok" results counted
fail_cnt_o  out  CNT_W  "not ok" results counted
err_o  out  1  sticky error flag
err_code_o  out  3  first error code seen
done_o  out  1  plan_valid_o and pass+fail == plan_o
all_pass_o  out  1  done_o and fail_cnt_o==0 and !err_o

Behaviour:
- Byte accepted when valid_i && ready_o. ready_o = !ev_valid_o: no byte is accepted while an event is pending.
- Reset (rst_n low at clk edge): all outputs 0, FSM to LINE_START, digit accumulator and expected number cleared. Reset mid-line discards the partial line and any pending event.
- '\r' (0x0D) is ignored in every state.
- FSM states:
  - LINE_START. '1' goes to PLAN_DOT1. 'n' goes to NOT_O. 'o' goes to OK_K. '#' goes to SKIP. '\n' stays in LINE_START. Any other byte raises err 1 and goes to SKIP.
  - PLAN_DOT1, then PLAN_DOT2: each expects '.'.
  - PLAN_NUM: accepts digits, then '\n'.
  - NOT_O, NOT_T, NOT_SP: expect 'o', 't', ' ' in turn; NOT_SP then goes to OK_O.
  - OK_O: expects 'o'.
  - OK_K: expects 'k'.
  - OK_SP: expects ' '.
  - NUM: needs at least one digit. Ends on ' ' (go to SKIP_DESC) or '\n' (finish line).
  - SKIP_DESC / SKIP: discard bytes until '\n'.
  - Any unexpected byte in a fixed-token state raises err 1 and goes to SKIP. If that byte is '\n', go straight to LINE_START.
- Number accumulation: acc = acc*10 + (byte-0x30).
  - A digit count above MAX_DIGITS, or acc exceeding 2^CNT_W-1, raises err 5. Remainder of the line is skipped with no event.
- Plan line completes on '\n' in PLAN_NUM:
  - plan_o = acc, plan_valid_o = 1, both held until reset.
  - A second plan line raises err 3 and is ignored.
  - A plan of 0 raises err 1.
- Result line completes on '\n' after NUM or SKIP_DESC:
  - No plan yet: err 2, no event.
  - Otherwise ev_valid_o = 1 in the cycle after the '\n' is accepted. It holds ev_ok_o and ev_num_o until ev_valid_o && ev_ready_i.
  - pass_cnt_o or fail_cnt_o increments in the same cycle ev_valid_o rises.
  - Event is still emitted with its parsed values if ev_num_o != expected (expected = pass+fail+1 before the increment); raises err 4.
  - Event is still emitted if ev_num_o > plan_o; raises err 6.
- Error codes: 1 syntax, 2 no plan, 3 duplicate plan, 4 sequence, 5 overflow, 6 beyond plan.
  - err_o and err_code_o latch the first error only. Later errors are ignored until reset.
  - The parser keeps running after an error, resyncing at the next '\n'.
- Counters saturate at 2^CNT_W-1.
- done_o and all_pass_o are combinational from registered state.
- Simultaneous ev_ready_i and a new valid_i: the byte is not accepted that cycle (ready_o is low). It is accepted the following cycle.

Test Plan:
- Stream "1..3\nok 1 a\nnot ok 2 b\nok 3\n" with ev_ready_i=1.
  - plan_o=3.
  - Events (1,1), (0,2), (1,3).
  - pass=2, fail=1, done_o=1, all_pass_o=0, err_o=0.
- Stream "ok 1\n1..1\n".
  - err_code_o=2, no event for the first line.
  - plan_o=1, done_o=0.
- Stream "1..2\nok 2\nok 1\n".
  - Events num 2 then 1.
  - err_code_o=4, latched from the first mismatch.
  - done_o=1.
- Hold ev_ready_i=0 for 5 cycles after the '\n' of "1..1\nok 1\n" while valid_i=1 with '#'.
  - ready_o=0 and ev_valid_o held high for 5 cycles.
  - The '#' byte is accepted in the cycle after ev_ready_i rises.
- With CNT_W=16, stream "1..70000\n".
  - err_code_o=5, plan_valid_o=0.
- Assert rst_n=0 after "1..4\nok 1 x" mid-line.
  - All outputs 0.
  - Then "1..1\r\nok 1\r\n" yields plan_o=1, pass=1, all_pass_o=1.
